eth_pipe: RTL and testbench



---
 rtl/eth_pipe.sv | 171 +++++++++++++++++
 tb/tb_eth_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pipe.sv
// GMII receive pipeline: captures one Ethernet frame at a time into a host RX slot
// (header words 0..2, frame data from word 3), timestamped from a free-running counter.
module eth_pipe (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        global_counter_rst,
  output logic [63:0] global_counter,
  input  logic [7:0]  gmii0_rxd,
  input  logic        gmii0_rx_dv,
  output logic [7:0]  gmii0_txd,
  output logic        gmii0_tx_en,
  output logic [31:0] slot0_rx_eth_data,
  output logic [3:0]  slot0_rx_eth_byte_en,
  output logic [10:0] slot0_rx_eth_address,
  output logic        slot0_rx_eth_wr_en,
  input  logic        slot0_rx_empty,
  output logic        slot0_rx_complete
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] PREAMBLE = 4'd1;
  localparam logic [3:0] DATA     = 4'd2;
  localparam logic [3:0] FLUSH    = 4'd3;
  localparam logic [3:0] HDR0     = 4'd4;
  localparam logic [3:0] HDR1     = 4'd5;
  localparam logic [3:0] HDR2     = 4'd6;
  localparam logic [3:0] DONE     = 4'd7;
  localparam logic [3:0] DROP     = 4'd8;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  logic [7:0]  rxd_q;
  logic        dv_q;
  logic [3:0]  state;
  logic [63:0] timestamp;
  logic [15:0] length;
  logic [1:0]  lane;
  logic [23:0] word_buf;
  logic [11:0] wr_addr;
  logic        slot_full;

  assign gmii0_txd   = 8'h00;
  assign gmii0_tx_en = 1'b0;

  // Slot writes are registered on the transition, so each state name matches the word
  // currently on the slot bus (FLUSH carries the partial word, HDRn carries word n).
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rxd_q                <= 8'h00;
      dv_q                 <= 1'b0;
      global_counter       <= 64'd0;
      state                <= IDLE;
      timestamp            <= 64'd0;
      length               <= 16'd0;
      lane                 <= 2'd0;
      word_buf             <= 24'd0;
      wr_addr              <= 12'd0;
      slot_full            <= 1'b0;
      slot0_rx_eth_data    <= 32'd0;
      slot0_rx_eth_byte_en <= 4'h0;
      slot0_rx_eth_address <= 11'd0;
      slot0_rx_eth_wr_en   <= 1'b0;
      slot0_rx_complete    <= 1'b0;
    end else begin
      rxd_q <= gmii0_rxd;
      dv_q  <= gmii0_rx_dv;

      if (global_counter_rst) global_counter <= 64'd0;
      else                    global_counter <= global_counter + 64'd1;

      slot0_rx_eth_data    <= 32'd0;
      slot0_rx_eth_byte_en <= 4'h0;
      slot0_rx_eth_address <= 11'd0;
      slot0_rx_eth_wr_en   <= 1'b0;
      slot0_rx_complete    <= 1'b0;

      if (!slot0_rx_empty) slot_full <= 1'b0;

      case (state)
        IDLE: begin
          if (dv_q) state <= (rxd_q == PRE_BYTE) ? PREAMBLE : DROP;
        end
        PREAMBLE: begin
          if (!dv_q) begin
            state <= IDLE;
          end else if (rxd_q == PRE_BYTE) begin
            state <= PREAMBLE;
          end else if (rxd_q == SFD_BYTE && slot0_rx_empty && !slot_full) begin
            timestamp <= global_counter;
            length    <= 16'd0;
            lane      <= 2'd0;
            word_buf  <= 24'd0;
            wr_addr   <= 12'd3;
            state     <= DATA;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (dv_q) begin
            if (length != 16'hFFFF) length <= length + 16'd1;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word_buf[7:0]   <= rxd_q;
              2'd1: word_buf[15:8]  <= rxd_q;
              2'd2: word_buf[23:16] <= rxd_q;
              default: begin
                // wr_addr[11] marks the slot as overflowed; keep it parked there.
                if (!wr_addr[11]) begin
                  slot0_rx_eth_data    <= {rxd_q, word_buf};
                  slot0_rx_eth_byte_en <= 4'hF;
                  slot0_rx_eth_address <= wr_addr[10:0];
                  slot0_rx_eth_wr_en   <= 1'b1;
                  wr_addr              <= wr_addr + 12'd1;
                end
                word_buf <= 24'd0;
              end
            endcase
          end else begin
            if (lane != 2'd0 && !wr_addr[11]) begin
              slot0_rx_eth_data    <= {8'h00, word_buf};
              slot0_rx_eth_address <= wr_addr[10:0];
              slot0_rx_eth_wr_en   <= 1'b1;
              case (lane)
                2'd1:    slot0_rx_eth_byte_en <= 4'h1;
                2'd2:    slot0_rx_eth_byte_en <= 4'h3;
                default: slot0_rx_eth_byte_en <= 4'h7;
              endcase
            end
            state <= FLUSH;
          end
        end
        FLUSH: begin
          slot0_rx_eth_data    <= {16'h0000, length};
          slot0_rx_eth_byte_en <= 4'hF;
          slot0_rx_eth_address <= 11'd0;
          slot0_rx_eth_wr_en   <= 1'b1;
          state                <= HDR0;
        end
        HDR0: begin
          slot0_rx_eth_data    <= timestamp[31:0];
          slot0_rx_eth_byte_en <= 4'hF;
          slot0_rx_eth_address <= 11'd1;
          slot0_rx_eth_wr_en   <= 1'b1;
          state                <= HDR1;
        end
        HDR1: begin
          slot0_rx_eth_data    <= timestamp[63:32];
          slot0_rx_eth_byte_en <= 4'hF;
          slot0_rx_eth_address <= 11'd2;
          slot0_rx_eth_wr_en   <= 1'b1;
          state                <= HDR2;
        end
        HDR2: begin
          slot0_rx_complete <= 1'b1;
          slot_full         <= 1'b1;
          state             <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        DROP: begin
          if (!dv_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_pipe.sv
// Directed testbench for eth_pipe: drives GMII frames and checks the slot write
// stream, header contents, timing and the slot-free handshake.
module tb_eth_pipe;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        global_counter_rst;
  logic [63:0] global_counter;
  logic [7:0]  gmii0_rxd;
  logic        gmii0_rx_dv;
  logic [7:0]  gmii0_txd;
  logic        gmii0_tx_en;
  logic [31:0] slot0_rx_eth_data;
  logic [3:0]  slot0_rx_eth_byte_en;
  logic [10:0] slot0_rx_eth_address;
  logic        slot0_rx_eth_wr_en;
  logic        slot0_rx_empty;
  logic        slot0_rx_complete;

  always #4 sys_clk = ~sys_clk;

  eth_pipe dut (
    .sys_clk              (sys_clk),
    .sys_rst_n            (sys_rst_n),
    .global_counter_rst   (global_counter_rst),
    .global_counter       (global_counter),
    .gmii0_rxd            (gmii0_rxd),
    .gmii0_rx_dv          (gmii0_rx_dv),
    .gmii0_txd            (gmii0_txd),
    .gmii0_tx_en          (gmii0_tx_en),
    .slot0_rx_eth_data    (slot0_rx_eth_data),
    .slot0_rx_eth_byte_en (slot0_rx_eth_byte_en),
    .slot0_rx_eth_address (slot0_rx_eth_address),
    .slot0_rx_eth_wr_en   (slot0_rx_eth_wr_en),
    .slot0_rx_empty       (slot0_rx_empty),
    .slot0_rx_complete    (slot0_rx_complete)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem    [0:2047];
  logic [3:0]  beLog  [0:2047];
  int          wrCyc  [0:2047];
  int          wrCount = 0;
  int          cmpCount = 0;
  int          cmpCyc = 0;
  int          busErr = 0;
  int          posCount = 0;
  logic [63:0] modelCnt = 64'd0;

  logic [63:0] expTs = 64'd0;
  logic        sfdPending = 1'b0;
  int          byte3Cyc = 0;
  int          dvLowCyc = 0;
  int          wrBase = 0;
  int          cmpBase = 0;

  // Reference cycle counter: what global_counter should read after each edge.
  always @(posedge sys_clk) begin
    posCount <= posCount + 1;
    modelCnt <= (!sys_rst_n || global_counter_rst) ? 64'd0 : modelCnt + 64'd1;
  end

  // Log every slot write by address and flag bus values leaking outside wr_en.
  always @(negedge sys_clk) begin
    if (slot0_rx_eth_wr_en) begin
      mem[slot0_rx_eth_address]   = slot0_rx_eth_data;
      beLog[slot0_rx_eth_address] = slot0_rx_eth_byte_en;
      wrCyc[slot0_rx_eth_address] = posCount;
      wrCount++;
    end else if (slot0_rx_eth_data != 32'd0 || slot0_rx_eth_byte_en != 4'h0 ||
                 slot0_rx_eth_address != 11'd0) begin
      busErr++;
    end
    if (slot0_rx_complete) begin
      cmpCount++;
      cmpCyc = posCount;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One GMII cycle; the value following an SFD is when the SFD leaves the input stage.
  task automatic applyStimulus(input logic dv, input logic [7:0] d);
    @(posedge sys_clk);
    #1;
    gmii0_rx_dv = dv;
    gmii0_rxd   = d;
    if (sfdPending) begin
      expTs      = modelCnt;
      sfdPending = 1'b0;
    end
    if (dv && d == 8'hD5) sfdPending = 1'b1;
  endtask

  task automatic markBase();
    wrBase  = wrCount;
    cmpBase = cmpCount;
  endtask

  task automatic sendFrame(input int n, input logic [7:0] base);
    markBase();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'hD5);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, base + 8'(i));
      if (i == 3) byte3Cyc = posCount;
    end
    applyStimulus(1'b0, 8'h00);
    dvLowCyc = posCount;
    repeat (11) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic releaseSlot();
    slot0_rx_empty = 1'b0;
    repeat (2) applyStimulus(1'b0, 8'h00);
    slot0_rx_empty = 1'b1;
    applyStimulus(1'b0, 8'h00);
  endtask

  initial begin
    sys_rst_n          = 1'b0;
    global_counter_rst = 1'b0;
    gmii0_rx_dv        = 1'b0;
    gmii0_rxd          = 8'h00;
    slot0_rx_empty     = 1'b1;

    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("rst_counter", global_counter, 64'd0);
    checkOutput("rst_wr_en", {63'd0, slot0_rx_eth_wr_en}, 64'd0);
    checkOutput("rst_complete", {63'd0, slot0_rx_complete}, 64'd0);
    checkOutput("rst_bus", {21'd0, slot0_rx_eth_address, slot0_rx_eth_byte_en,
                slot0_rx_eth_data}, 64'd0);
    checkOutput("rst_tx", {55'd0, gmii0_tx_en, gmii0_txd}, 64'd0);

    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    checkOutput("cnt_0", global_counter, 64'd0);
    @(negedge sys_clk);
    checkOutput("cnt_1", global_counter, 64'd1);
    @(negedge sys_clk);
    checkOutput("cnt_2", global_counter, 64'd2);
    @(posedge sys_clk);
    #1 global_counter_rst = 1'b1;
    @(posedge sys_clk);
    #1 global_counter_rst = 1'b0;
    @(negedge sys_clk);
    checkOutput("cnt_clr", global_counter, 64'd0);
    @(negedge sys_clk);
    checkOutput("cnt_after_clr", global_counter, 64'd1);

    $display("[TB] 64-byte frame");
    sendFrame(64, 8'h00);
    checkOutput("f64_w3", {32'd0, mem[3]}, 64'h03020100);
    checkOutput("f64_w18", {32'd0, mem[18]}, 64'h3F3E3D3C);
    checkOutput("f64_be18", {60'd0, beLog[18]}, 64'hF);
    checkOutput("f64_len", {32'd0, mem[0]}, 64'h40);
    checkOutput("f64_ts_lo", {32'd0, mem[1]}, {32'd0, expTs[31:0]});
    checkOutput("f64_ts_hi", {32'd0, mem[2]}, {32'd0, expTs[63:32]});
    checkOutput("f64_writes", 64'(wrCount - wrBase), 64'd19);
    checkOutput("f64_complete", 64'(cmpCount - cmpBase), 64'd1);
    checkOutput("f64_data_lat", 64'(wrCyc[3] - byte3Cyc), 64'd2);
    checkOutput("f64_hdr2_lat", 64'(wrCyc[2] - dvLowCyc), 64'd5);
    checkOutput("f64_cmp_lat", 64'(cmpCyc - dvLowCyc), 64'd6);
    releaseSlot();

    $display("[TB] 61-byte frame");
    sendFrame(61, 8'h00);
    checkOutput("f61_w18", {32'd0, mem[18]}, 64'h0000003C);
    checkOutput("f61_be18", {60'd0, beLog[18]}, 64'h1);
    checkOutput("f61_len", {32'd0, mem[0]}, 64'h3D);
    checkOutput("f61_flush_lat", 64'(wrCyc[18] - dvLowCyc), 64'd2);
    checkOutput("f61_writes", 64'(wrCount - wrBase), 64'd19);
    checkOutput("f61_complete", 64'(cmpCount - cmpBase), 64'd1);

    $display("[TB] slot busy at SFD");
    slot0_rx_empty = 1'b0;
    sendFrame(16, 8'h00);
    checkOutput("busy_writes", 64'(wrCount - wrBase), 64'd0);
    checkOutput("busy_complete", 64'(cmpCount - cmpBase), 64'd0);
    slot0_rx_empty = 1'b1;
    applyStimulus(1'b0, 8'h00);

    $display("[TB] back-to-back frames");
    sendFrame(12, 8'h10);
    checkOutput("b2b_a_len", {32'd0, mem[0]}, 64'hC);
    checkOutput("b2b_a_complete", 64'(cmpCount - cmpBase), 64'd1);
    sendFrame(20, 8'h20);
    checkOutput("b2b_b_writes", 64'(wrCount - wrBase), 64'd0);
    checkOutput("b2b_b_complete", 64'(cmpCount - cmpBase), 64'd0);
    releaseSlot();
    sendFrame(8, 8'h40);
    checkOutput("b2b_c_len", {32'd0, mem[0]}, 64'h8);
    checkOutput("b2b_c_w4", {32'd0, mem[4]}, 64'h47464544);
    checkOutput("b2b_c_complete", 64'(cmpCount - cmpBase), 64'd1);
    releaseSlot();

    $display("[TB] corrupted preamble and early rx_dv drop");
    markBase();
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'h12);
    repeat (5) applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'hD5);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i));
    repeat (12) applyStimulus(1'b0, 8'h00);
    repeat (3) applyStimulus(1'b1, 8'h55);
    repeat (12) applyStimulus(1'b0, 8'h00);
    checkOutput("bad_pre_writes", 64'(wrCount - wrBase), 64'd0);
    checkOutput("bad_pre_complete", 64'(cmpCount - cmpBase), 64'd0);
    sendFrame(9, 8'h80);
    checkOutput("recov_w3", {32'd0, mem[3]}, 64'h83828180);
    checkOutput("recov_w5", {32'd0, mem[5]}, 64'h00000088);
    checkOutput("recov_len", {32'd0, mem[0]}, 64'h9);
    checkOutput("recov_complete", 64'(cmpCount - cmpBase), 64'd1);
    releaseSlot();

    $display("[TB] zero-length frame");
    sendFrame(0, 8'h00);
    checkOutput("zero_len", {32'd0, mem[0]}, 64'h0);
    checkOutput("zero_writes", 64'(wrCount - wrBase), 64'd3);
    checkOutput("zero_ts_lo", {32'd0, mem[1]}, {32'd0, expTs[31:0]});
    checkOutput("zero_complete", 64'(cmpCount - cmpBase), 64'd1);
    releaseSlot();

    $display("[TB] reset mid-frame");
    markBase();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'hD5);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'hA0 + 8'(i));
    applyStimulus(1'b0, 8'h00);
    sys_rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    sys_rst_n = 1'b1;
    repeat (12) applyStimulus(1'b0, 8'h00);
    checkOutput("midrst_writes", 64'(wrCount - wrBase), 64'd1);
    checkOutput("midrst_complete", 64'(cmpCount - cmpBase), 64'd0);

    checkOutput("bus_idle_zero", 64'(busErr), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
